hog_svm_classifier: RTL and testbench

Linear-SVM scoring stage directly downstream of the HOG feature buffer. Once the buffer has been filled, this block walks all feature addresses. It multiplies each feature by the matching weight from an external weight ROM and accumulates the products with a bias. It then outputs a saturated detection score and a human/no-human decision, one result per 64x128 detection window.

---
 rtl/hog_svm_classifier.sv | 135 +++++++++++++
 tb/tb_hog_svm_classifier.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hog_svm_classifier.sv
// Linear-SVM scorer: walks the HOG feature buffer and the weight ROM in lockstep, then
// accumulates feature*weight on top of the bias and emits a saturated Q16.16 score.
module hog_svm_classifier #(
  parameter int                 N_FEAT    = 3780,
  parameter int                 ADDR_W    = 12,
  parameter int                 FRAC      = 16,
  parameter int                 ACC_W     = 80,
  parameter logic signed [31:0] THRESHOLD = 32'sd0
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [31:0]       iBias,
  output logic [ADDR_W-1:0] oADDR,
  input  logic [31:0]       iFeature,
  input  logic [31:0]       iWeight,
  output logic              oBusy,
  output logic              oValid,
  output logic [31:0]       oScore,
  output logic              oHuman
);

  localparam int                STAGES = 2;
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(N_FEAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      drain_q, drain_d;
  logic                      busy_q, busy_d;
  logic                      valid_q, valid_d;
  logic [31:0]               score_q, score_d;
  logic                      human_q, human_d;
  logic                      acc_load;

  logic [STAGES:1]           vld_pipe_q;
  logic signed [31:0]        feat_q, wt_q;
  logic signed [63:0]        prod_q;
  logic signed [ACC_W-1:0]   acc_q;

  logic signed [ACC_W-1:0]   shifted;
  logic [ACC_W-32:0]         top_bits;
  logic                      ovf;
  logic [31:0]               score_sat;

  // Score fits in 32 bits only when every bit above bit 31 matches the sign.
  always_comb begin
    shifted   = acc_q >>> FRAC;
    top_bits  = shifted[ACC_W-1:31];
    ovf       = !((&top_bits) || !(|top_bits));
    score_sat = shifted[31:0];
    if (ovf) score_sat = shifted[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    drain_d  = drain_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    score_d  = score_q;
    human_d  = human_q;
    acc_load = 1'b0;
    case (state_q)
      IDLE: if (iStart) begin
        state_d  = RUN;
        addr_d   = '0;
        busy_d   = 1'b1;
        acc_load = 1'b1;
      end
      RUN: begin
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == LAST) begin
          state_d = DRAIN;
          addr_d  = '0;
          drain_d = 1'b0;
        end
      end
      // Two cycles lets the last pair pass through the product and accumulate stages.
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      DONE: begin
        score_d = score_sat;
        human_d = $signed(score_sat) > THRESHOLD;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      drain_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      score_q    <= '0;
      human_q    <= 1'b0;
      vld_pipe_q <= '0;
      feat_q     <= '0;
      wt_q       <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      drain_q    <= drain_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      score_q    <= score_d;
      human_q    <= human_d;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], state_q == RUN};
      feat_q     <= $signed(iFeature);
      wt_q       <= $signed(iWeight);
      prod_q     <= 64'(feat_q) * 64'(wt_q);
      if (acc_load)
        acc_q <= ACC_W'($signed(iBias)) <<< FRAC;
      else if (vld_pipe_q[STAGES])
        acc_q <= acc_q + ACC_W'(prod_q);
    end
  end

  assign oADDR  = addr_q;
  assign oBusy  = busy_q;
  assign oValid = valid_q;
  assign oScore = score_q;
  assign oHuman = human_q;

endmodule

// File: tb/tb_hog_svm_classifier.sv
// Scoreboard bench for hog_svm_classifier: directed windows push expected results,
// a negedge monitor pops and compares score, decision and latency on each oValid.
module tb_hog_svm_classifier;
  localparam int N   = 3780;
  localparam int LAT = N + 3;

  logic        iClk = 1'b0;
  logic        iRst, iStart;
  logic [31:0] iBias, iFeature, iWeight;
  logic [11:0] oADDR;
  logic        oBusy, oValid, oHuman;
  logic [31:0] oScore;

  hog_svm_classifier dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iBias(iBias), .oADDR(oADDR),
    .iFeature(iFeature), .iWeight(iWeight), .oBusy(oBusy), .oValid(oValid),
    .oScore(oScore), .oHuman(oHuman)
  );

  always #5 iClk = ~iClk;

  // Feature source: mode 0 = every address returns fval, mode 1 = only address sel does.
  logic [31:0] fval, wval;
  int          mode, sel;
  always_comb begin
    iFeature = (mode == 0 || int'(oADDR) == sel) ? fval : 32'h0;
    iWeight  = wval;
  end

  typedef struct {logic [31:0] score; logic human; int cyc;} exp_t;
  exp_t q[$];
  int tests, fails, cyc, nvalid;

  always @(posedge iClk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge iClk) begin
    if (!iRst && oValid) begin
      nvalid++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got oValid=1 expected no result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("score", {32'h0, oScore}, {32'h0, e.score});
        chk("human", {63'h0, oHuman}, {63'h0, e.human});
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Issue a start at the current negedge; bias is scrambled after acceptance.
  task automatic start(input logic [31:0] bias, input logic [31:0] score, input logic human);
    iBias  = bias;
    iStart = 1'b1;
    q.push_back('{score, human, cyc + 1 + LAT});
    @(negedge iClk);
    iStart = 1'b0;
    iBias  = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(negedge iClk);
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no oValid expected %0d result(s)", q.size());
      q.delete();
    end
    @(negedge iClk);
  endtask

  task automatic run(input logic [31:0] f, input logic [31:0] w, input logic [31:0] bias,
                     input logic [31:0] score, input logic human);
    fval = f;
    wval = w;
    start(bias, score, human);
    wait_done();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, nv0, n;
    iRst = 1'b1; iStart = 1'b0; iBias = '0; fval = '0; wval = '0; mode = 0; sel = 0;
    repeat (3) @(negedge iClk);
    chk("rst_addr", 64'(oADDR), 0);
    chk("rst_busy", 64'(oBusy), 0);
    chk("rst_valid", 64'(oValid), 0);
    chk("rst_score", 64'(oScore), 0);
    chk("rst_human", 64'(oHuman), 0);
    iRst = 1'b0;
    @(negedge iClk);

    // Zero features: score is the bias alone; address walk checked cycle by cycle.
    fval = 32'h0; wval = 32'h1234_5678;
    start(32'h0001_0000, 32'h0001_0000, 1'b1);
    chk("busy_run", 64'(oBusy), 1);
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (int'(oADDR) != i) bad++;
      @(negedge iClk);
    end
    chk("addr_seq_errors", 64'(bad), 0);
    chk("addr_return", 64'(oADDR), 0);
    wait_done();

    run(32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0EC4_0000, 1'b1);
    repeat (5) @(negedge iClk);
    chk("score_hold", 64'(oScore), 64'h0EC4_0000);
    chk("busy_idle", 64'(oBusy), 0);

    run(32'h0001_0000, 32'hFFFF_0000, 32'h0, 32'hF13C_0000, 1'b0);
    run(32'h0001_0000, 32'h0,         32'h0, 32'h0,         1'b0);
    run(32'h0, 32'h0, 32'h0000_0001, 32'h0000_0001, 1'b1);
    run(32'h7FFF_0000, 32'h7FFF_0000, 32'h0, 32'h7FFF_FFFF, 1'b1);
    run(32'h7FFF_0000, 32'h8001_0000, 32'h0, 32'h8000_0000, 1'b0);

    // Single nonzero feature at the last and first addresses, with fractional bias.
    mode = 1; sel = N - 1;
    run(32'h0001_0000, 32'h0002_0000, 32'hFFFF_8000, 32'h0001_8000, 1'b1);
    sel = 0;
    run(32'h0001_0000, 32'hFFFE_0000, 32'h0001_8000, 32'hFFFF_8000, 1'b0);
    mode = 0;

    // Starts during RUN are ignored; a start in the oValid cycle is taken back-to-back.
    nv0 = nvalid;
    fval = 32'h0001_0000; wval = 32'h0001_0000;
    start(32'h0, 32'h0EC4_0000, 1'b1);
    repeat (99) @(negedge iClk);
    iStart = 1'b1; @(negedge iClk); iStart = 1'b0;
    repeat (1899) @(negedge iClk);
    iStart = 1'b1; @(negedge iClk); iStart = 1'b0;
    n = 0;
    while (!oValid && n < 5000) begin
      @(negedge iClk);
      n++;
    end
    chk("first_valid_seen", 64'(oValid), 1);
    fval = 32'h0002_0000;
    start(32'h0, 32'h1D88_0000, 1'b1);
    chk("b2b_busy", 64'(oBusy), 1);
    chk("b2b_addr", 64'(oADDR), 0);
    wait_done();
    chk("valid_count", 64'(nvalid - nv0), 2);

    // Reset mid-run discards the window; a fresh run reproduces the all-ones score.
    fval = 32'h0001_0000;
    start(32'h0, 32'h0EC4_0000, 1'b1);
    n = 0;
    while (oADDR != 12'd2000 && n < 5000) begin
      @(negedge iClk);
      n++;
    end
    chk("addr_reached_2000", 64'(oADDR), 2000);
    iRst = 1'b1;
    q.delete();
    @(negedge iClk);
    chk("midrst_busy", 64'(oBusy), 0);
    chk("midrst_addr", 64'(oADDR), 0);
    chk("midrst_valid", 64'(oValid), 0);
    iRst = 1'b0;
    nv0 = nvalid;
    repeat (10) @(negedge iClk);
    run(32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0EC4_0000, 1'b1);
    repeat (20) @(negedge iClk);
    chk("post_rst_valid_count", 64'(nvalid - nv0), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
